// File: rtl/mcbsp_slave.sv
// mcbsp_slave: receive-side McBSP endpoint.
// Oversamples clkr/fsr/mosi on mcbsp_clk_in, deserialises MSB-first words of
// 1..32 bits, strobes each word out, counts words per frame, and flags
// frame-sync errors and a stalled serial clock.
// Optional feature macro: MCBSP_SLAVE_SIGN_EXT_EN (sign-extend words shorter
// than 32 bits; when undefined the unused upper bits are zero).
module mcbsp_slave #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        mcbsp_clk_in,
   input  logic        mcbsp_rst_in,
   input  logic [14:0] mcbsp_reg_number,
   input  logic [6:0]  mcbsp_reg_length,
   input  logic        mcbsp_slave_en,
   input  logic        mcbsp_slave_clkr,
   input  logic        mcbsp_slave_fsr,
   input  logic        mcbsp_slave_mosi,
   output logic [31:0] mcbsp_data_out,
   output logic        mcbsp_data_valid,
   output logic        mcbsp_frame_done,
   output logic [14:0] mcbsp_word_count,
   output logic        mcbsp_err_fs,
   output logic        mcbsp_timeout,
   output logic [63:0] debug_signal
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      WAIT_FS = 2'd2
   } state_t;

   state_t state, next_state;

   logic [SYNC_STAGES-1:0] clkr_sync, fsr_sync, mosi_sync;
   logic              clkr_d;
   logic              sync_clkr, sync_fsr, sync_mosi, rise;

   logic [6:0]        bit_cnt;
   logic [14:0]       word_cnt;
   logic [31:0]       shift_reg;
   logic [6:0]        len_q;
   logic [14:0]       num_q;
   logic [TMO_W-1:0]  tmo_cnt;

   logic [6:0]        len_eff;
   logic [14:0]       num_eff;
   logic              final_bit;
   logic [31:0]       shift_next;
   logic [14:0]       word_inc;
   logic              frame_end;
   logic              tmo_hit;
   logic [31:0]       len_mask;
   logic [31:0]       word_value;

   logic              word_done, frame_hit, fs_err, tmo_pulse;

   assign sync_clkr = clkr_sync[SYNC_STAGES-1];
   assign sync_fsr  = fsr_sync[SYNC_STAGES-1];
   assign sync_mosi = mosi_sync[SYNC_STAGES-1];
   assign rise      = sync_clkr & ~clkr_d;

   assign len_eff   = (mcbsp_reg_length == 7'd0 || mcbsp_reg_length > 7'd32) ? 7'd32 : mcbsp_reg_length;
   assign num_eff   = (mcbsp_reg_number == 15'd0) ? 15'd1 : mcbsp_reg_number;
   assign final_bit = (bit_cnt == len_q - 7'd1);
   assign shift_next = {shift_reg[30:0], sync_mosi};
   assign word_inc  = word_cnt + 15'd1;
   assign frame_end = (word_inc == num_q);
   assign tmo_hit   = (state != IDLE) && !rise && (tmo_cnt == TMO_MAX);
   assign len_mask  = (len_q == 7'd32) ? 32'hFFFF_FFFF : ((32'd1 << len_q[4:0]) - 32'd1);

`ifdef MCBSP_SLAVE_SIGN_EXT_EN
   assign word_value = (shift_next & len_mask) |
                       ((len_q != 7'd32 && shift_next[5'(len_q - 7'd1)]) ? ~len_mask : 32'd0);
`else
   assign word_value = shift_next & len_mask;
`endif

   // Bring the asynchronous serial lines into the local clock domain, all with equal depth.
   always_ff @(posedge mcbsp_clk_in) begin
      if (mcbsp_rst_in) begin
         clkr_sync <= '0;
         fsr_sync  <= '0;
         mosi_sync <= '0;
         clkr_d    <= 1'b0;
      end else begin
         clkr_sync <= {clkr_sync[SYNC_STAGES-2:0], mcbsp_slave_clkr};
         fsr_sync  <= {fsr_sync[SYNC_STAGES-2:0], mcbsp_slave_fsr};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mcbsp_slave_mosi};
         clkr_d    <= sync_clkr;
      end
   end

   // State register.
   always_ff @(posedge mcbsp_clk_in) begin
      if (mcbsp_rst_in) state <= IDLE;
      else              state <= next_state;
   end

   // Next-state decode: disable and timeout abort to IDLE, otherwise advance on clkr rises.
   always_comb begin
      next_state = state;
      if (!mcbsp_slave_en || tmo_hit) begin
         next_state = IDLE;
      end else if (rise) begin
         case (state)
            IDLE:    if (sync_fsr) next_state = SHIFT;
            SHIFT: begin
               if (final_bit) begin
                  if (sync_fsr)       next_state = SHIFT;
                  else if (frame_end) next_state = IDLE;
                  else                next_state = WAIT_FS;
               end
            end
            WAIT_FS: if (sync_fsr) next_state = SHIFT;
            default: next_state = IDLE;
         endcase
      end
   end

   // Event decode for the one-cycle strobes that are registered next edge.
   always_comb begin
      word_done = 1'b0;
      frame_hit = 1'b0;
      fs_err    = 1'b0;
      tmo_pulse = 1'b0;
      if (mcbsp_slave_en) begin
         tmo_pulse = tmo_hit;
         if (!tmo_hit && rise && state == SHIFT) begin
            word_done = final_bit;
            frame_hit = final_bit && frame_end;
            fs_err    = !final_bit && sync_fsr;
         end
      end
   end

   // Datapath: strobes, received word, counters, shift register and per-frame configuration.
   always_ff @(posedge mcbsp_clk_in) begin
      if (mcbsp_rst_in) begin
         mcbsp_data_out   <= '0;
         mcbsp_data_valid <= 1'b0;
         mcbsp_frame_done <= 1'b0;
         mcbsp_err_fs     <= 1'b0;
         mcbsp_timeout    <= 1'b0;
         bit_cnt          <= '0;
         word_cnt         <= '0;
         shift_reg        <= '0;
         len_q            <= '0;
         num_q            <= '0;
         tmo_cnt          <= '0;
      end else begin
         mcbsp_data_valid <= word_done;
         mcbsp_frame_done <= frame_hit;
         mcbsp_err_fs     <= fs_err;
         mcbsp_timeout    <= tmo_pulse;
         if (word_done) mcbsp_data_out <= word_value;

         if (!mcbsp_slave_en || rise || state == IDLE) tmo_cnt <= '0;
         else if (tmo_cnt != TMO_MAX)                  tmo_cnt <= tmo_cnt + 1'b1;

         if (!mcbsp_slave_en || tmo_hit) begin
            bit_cnt   <= '0;
            word_cnt  <= '0;
            shift_reg <= '0;
         end else if (rise) begin
            case (state)
               IDLE: begin
                  if (sync_fsr) begin
                     bit_cnt   <= '0;
                     word_cnt  <= '0;
                     shift_reg <= '0;
                     len_q     <= len_eff;
                     num_q     <= num_eff;
                  end
               end
               SHIFT: begin
                  if (final_bit) begin
                     shift_reg <= shift_next;
                     bit_cnt   <= '0;
                     word_cnt  <= frame_end ? 15'd0 : word_inc;
                     if (sync_fsr && frame_end) begin
                        len_q <= len_eff;
                        num_q <= num_eff;
                     end
                  end else if (sync_fsr) begin
                     bit_cnt   <= '0;
                     shift_reg <= '0;
                  end else begin
                     shift_reg <= shift_next;
                     bit_cnt   <= bit_cnt + 7'd1;
                  end
               end
               WAIT_FS: begin
                  if (sync_fsr) begin
                     bit_cnt   <= '0;
                     shift_reg <= '0;
                  end
               end
               default: begin
                  bit_cnt <= '0;
               end
            endcase
         end
      end
   end

   assign mcbsp_word_count = word_cnt;
   assign debug_signal     = {7'd0, shift_reg, word_cnt, bit_cnt, state, rise};

endmodule
